// File: rtl/seq_addsub_if.sv
// seq_addsub_if -- handshake and data bundle for the sequential adder/subtractor.
//
// Parameter:
//   WIDTH      operand/result width; must match the WIDTH of the attached seq_addsub.
// Signals:
//   in_valid   operands and mode valid              (master -> slave)
//   in_ready   block can accept a new operation     (slave -> master)
//   a, b       operands                             (master -> slave)
//   sub        0: a+b+cin, 1: a-b                   (master -> slave)
//   cin        carry-in, add mode only              (master -> slave)
//   out_valid  result valid                         (slave -> master)
//   out_ready  consumer accepts the result          (master -> slave)
//   sum        result                               (slave -> master)
//   cout       carry out of the MSB (1 = no borrow in sub mode)
//   ovf        two's-complement overflow
//   zero       sum == 0
interface seq_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/seq_addsub.sv
// seq_addsub -- multi-cycle adder/subtractor using one CHUNK-bit ripple slice.
//
// An accepted operation runs for NCH = WIDTH/CHUNK cycles, one slice per clock,
// LSB slice first. The result and flags are then held (out_valid=1) until the
// consumer takes them with out_ready. Sum and flags keep their last values
// afterwards.
//
// Parameters:
//   WIDTH   operand/result width (multiple of CHUNK)
//   CHUNK   bits added per clock, 1 <= CHUNK <= WIDTH
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   bus     seq_addsub_if slave modport (handshakes, operands, result, flags)
// Optional build macro:
//   SEQ_ADDSUB_SAT_EN  when defined, an overflowing result is replaced by the
//                      signed saturation value (ovf still reads 1, zero is
//                      evaluated on the saturated value).
module seq_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic         clk,
  input logic         rst,
  seq_addsub_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_reg, state_next;
  // Operands are shifted right one slice per RUN cycle, so the active slice is
  // always in the low CHUNK bits; their MSBs are captured separately for ovf.
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] beff_reg, beff_next;
  logic             carry_reg, carry_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             msb_a_reg, msb_a_next;
  logic             msb_b_reg, msb_b_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
  logic             ovf_reg, ovf_next;
  logic             zero_reg, zero_next;

  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] sum_wr;    // sum_reg with the current slice written in
  logic             ovf_calc;
  logic [WIDTH-1:0] sum_done;  // value stored on the DONE-entry edge

  // The single ripple slice.
  assign slice_res = {1'b0, a_reg[CHUNK-1:0]}
                   + {1'b0, beff_reg[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, carry_reg};

  // Write the slice result into the chunk selected by the counter.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slice_wr
      assign sum_wr[gi*CHUNK +: CHUNK] = (cnt_reg == CW'(gi))
                                         ? slice_res[CHUNK-1:0]
                                         : sum_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Overflow: operands of equal sign producing a result of the other sign.
  assign ovf_calc = (msb_a_reg == msb_b_reg) && (sum_wr[WIDTH-1] != msb_a_reg);

`ifdef SEQ_ADDSUB_SAT_EN
  always_comb begin
    sum_done = sum_wr;
    if (ovf_calc) begin
      sum_done = msb_a_reg ? {1'b1, {(WIDTH-1){1'b0}}}
                           : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum_done = sum_wr;
`endif

  // Next-state and datapath updates.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    beff_next  = beff_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    msb_a_next = msb_a_reg;
    msb_b_next = msb_b_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
    ovf_next   = ovf_reg;
    zero_next  = zero_reg;

    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          state_next = RUN;
          a_next     = bus.a;
          // Subtraction as a + ~b + 1.
          beff_next  = bus.sub ? ~bus.b : bus.b;
          carry_next = bus.sub ? 1'b1 : bus.cin;
          cnt_next   = '0;
          msb_a_next = bus.a[WIDTH-1];
          msb_b_next = bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
        end
      end

      RUN: begin
        a_next     = a_reg >> CHUNK;
        beff_next  = beff_reg >> CHUNK;
        carry_next = slice_res[CHUNK];
        cnt_next   = cnt_reg + CW'(1);
        sum_next   = sum_wr;
        if (cnt_reg == CW'(NCH - 1)) begin
          state_next = DONE;
          cout_next  = slice_res[CHUNK];
          ovf_next   = ovf_calc;
          sum_next   = sum_done;
          // Taken from the completed result, including the slice just added.
          zero_next  = (sum_done == '0);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      beff_reg  <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      msb_a_reg <= 1'b0;
      msb_b_reg <= 1'b0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      zero_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      beff_reg  <= beff_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      msb_a_reg <= msb_a_next;
      msb_b_reg <= msb_b_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
      ovf_reg   <= ovf_next;
      zero_reg  <= zero_next;
    end
  end

  // Handshake outputs decode straight from the state register, so a reset
  // drops out_valid without waiting for a clock.
  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.sum       = sum_reg;
  assign bus.cout      = cout_reg;
  assign bus.ovf       = ovf_reg;
  assign bus.zero      = zero_reg;

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub -- directed self-checking bench for seq_addsub.
// Two instances: WIDTH=32/CHUNK=8 (4 RUN cycles) and WIDTH=16/CHUNK=16 (1 RUN cycle).
// Expected results come from a whole-word arithmetic model and are queued at
// issue time, then popped and compared when out_valid is seen.
module tb_seq_addsub;

  logic clk = 1'b0;
  logic rst;
  logic rst16;
  always #5 clk = ~clk;

  seq_addsub_if #(.WIDTH(32)) bus32 ();
  seq_addsub_if #(.WIDTH(16)) bus16 ();

  seq_addsub #(.WIDTH(32), .CHUNK(8)) dut32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32)
  );

  seq_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk),
    .rst(rst16),
    .bus(bus16)
  );

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
    exp_t        e;
    logic [31:0] mask;
    logic [31:0] am;
    logic [31:0] be;
    logic [32:0] full;
    logic        ma;
    logic        mb;
    mask = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am   = a & mask;
    be   = (sub ? ~b : b) & mask;
    full = {1'b0, am} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    ma     = am[w-1];
    mb     = be[w-1];
    e.ovf  = (ma == mb) && (e.sum[w-1] != ma);
`ifdef SEQ_ADDSUB_SAT_EN
    if (e.ovf) e.sum = ma ? (32'd1 << (w-1)) : ((32'd1 << (w-1)) - 32'd1);
`endif
    e.zero = (e.sum == 32'd0);
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_sum(int w);
    return (w == 32) ? bus32.sum : {16'd0, bus16.sum};
  endfunction
  function automatic logic get_cout(int w);  return (w == 32) ? bus32.cout      : bus16.cout;      endfunction
  function automatic logic get_ovf(int w);   return (w == 32) ? bus32.ovf       : bus16.ovf;       endfunction
  function automatic logic get_zero(int w);  return (w == 32) ? bus32.zero      : bus16.zero;      endfunction
  function automatic logic get_valid(int w); return (w == 32) ? bus32.out_valid : bus16.out_valid; endfunction
  function automatic logic get_ready(int w); return (w == 32) ? bus32.in_ready  : bus16.in_ready;  endfunction

  task automatic set_in(int w, logic v, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
    if (w == 32) begin
      bus32.in_valid = v; bus32.a = a; bus32.b = b; bus32.sub = sub; bus32.cin = cin;
    end else begin
      bus16.in_valid = v; bus16.a = a[15:0]; bus16.b = b[15:0]; bus16.sub = sub; bus16.cin = cin;
    end
  endtask

  task automatic set_oready(int w, logic r);
    if (w == 32) bus32.out_ready = r;
    else         bus16.out_ready = r;
  endtask

  // Called #1 after a clock edge with the DUT idle; returns #1 after the accepting edge.
  task automatic issue(int w, logic [31:0] a, logic [31:0] b, logic sub, logic cin);
    sb.push_back(model(w, a, b, sub, cin));
    set_in(w, 1'b1, a, b, sub, cin);
    @(posedge clk);
    #1;
    // Operands are free to change once accepted.
    set_in(w, 1'b0, $urandom, $urandom, ~sub, ~cin);
  endtask

  task automatic show_state(string tag, int w);
    chk({tag, " out_valid"}, {31'd0, get_valid(w)}, 32'd0);
    chk({tag, " in_ready"},  {31'd0, get_ready(w)}, 32'd1);
  endtask

  // Wait for the result, check latency/result/flags, optionally stall the
  // consumer for hold cycles (offering a new op meanwhile), then consume.
  task automatic collect(int w, int lat, string tag, int hold);
    int   n;
    exp_t e;
    n = 0;
    while (!get_valid(w) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, " sum"},      get_sum(w),            e.sum);
    chk({tag, " cout"},     {31'd0, get_cout(w)},  {31'd0, e.cout});
    chk({tag, " ovf"},      {31'd0, get_ovf(w)},   {31'd0, e.ovf});
    chk({tag, " zero"},     {31'd0, get_zero(w)},  {31'd0, e.zero});
    chk({tag, " in_ready"}, {31'd0, get_ready(w)}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      set_in(w, 1'b1, 32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk({tag, " hold sum"},       get_sum(w),             e.sum);
      chk({tag, " hold flags"},     {29'd0, get_cout(w), get_ovf(w), get_zero(w)},
                                    {29'd0, e.cout, e.ovf, e.zero});
      chk({tag, " hold out_valid"}, {31'd0, get_valid(w)},  32'd1);
      chk({tag, " hold in_ready"},  {31'd0, get_ready(w)},  32'd0);
    end
    set_oready(w, 1'b1);
    @(posedge clk);
    #1;
    set_oready(w, 1'b0);
    // in_valid may still be high here: it must not have been taken on the consume edge.
    show_state({tag, " consumed"}, w);
    set_in(w, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    chk({tag, " sum kept"}, get_sum(w), e.sum);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    rst16 = 1'b1;
    set_in(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_in(16, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    set_oready(32, 1'b0);
    set_oready(16, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    show_state("reset32", 32);
    chk("reset32 sum",   get_sum(32), 32'd0);
    chk("reset32 flags", {29'd0, get_cout(32), get_ovf(32), get_zero(32)}, 32'd0);
    show_state("reset16", 16);
    chk("reset16 sum",   get_sum(16), 32'd0);
    rst   = 1'b0;
    rst16 = 1'b0;
    @(posedge clk);
    #1;

    // 32-bit, 4 RUN cycles.
    issue(32, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0); collect(32, 4, "add_ff_1", 0);
    issue(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); collect(32, 4, "wrap_zero", 0);
    issue(32, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0); collect(32, 4, "pos_ovf", 0);
    issue(32, 32'd5,         32'd7,         1'b1, 1'b1); collect(32, 4, "sub_5_7", 0);
    issue(32, 32'd7,         32'd5,         1'b1, 1'b0); collect(32, 4, "sub_7_5", 0);
    issue(32, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0); collect(32, 4, "neg_ovf", 0);
    issue(32, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1); collect(32, 4, "add_cin", 0);
    issue(32, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0); collect(32, 4, "mid_carry", 0);
    issue(32, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1); collect(32, 4, "hold", 10);

    // Reset in the second RUN cycle discards the partial result.
    issue(32, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    show_state("rst_run32", 32);
    chk("rst_run32 sum", get_sum(32), 32'd0);
    void'(sb.pop_back());
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32, 32'd3, 32'd4, 1'b0, 1'b0); collect(32, 4, "after_rst32", 0);

    // Reset while a result is waiting drops out_valid at once.
    issue(32, 32'd10, 32'd20, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("rst_done32 pre out_valid", {31'd0, get_valid(32)}, 32'd1);
    rst = 1'b1;
    #1;
    show_state("rst_done32", 32);
    chk("rst_done32 sum", get_sum(32), 32'd0);
    void'(sb.pop_back());
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 16-bit, single RUN cycle.
    issue(16, 32'd3,    32'd4,    1'b0, 1'b0); collect(16, 1, "w16_add", 0);
    issue(16, 32'hFFFF, 32'h0001, 1'b0, 1'b0); collect(16, 1, "w16_wrap", 0);
    issue(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0); collect(16, 1, "w16_ovf", 0);
    issue(16, 32'd5,    32'd7,    1'b1, 1'b1); collect(16, 1, "w16_sub", 0);

    issue(16, 32'h00FF, 32'h0001, 1'b0, 1'b0);
    rst16 = 1'b1;
    #1;
    show_state("rst_run16", 16);
    chk("rst_run16 sum", get_sum(16), 32'd0);
    void'(sb.pop_back());
    #2;
    rst16 = 1'b0;
    @(posedge clk);
    #1;
    issue(16, 32'd3, 32'd4, 1'b0, 1'b0); collect(16, 1, "after_rst16", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
